// File: rtl/jt7759_pkg.sv
// Shared tables and helpers for the jt7759 ADPCM decoder.
// Step magnitudes above 127 are held at 127 so every step fits a signed byte.
package jt7759_pkg;

  localparam logic signed [7:0] SMAX = 8'sd127;
  localparam logic signed [7:0] SMIN = 8'h80;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_HI    = 2'd1,
    BUF_LO    = 2'd2
  } buf_st_t;

  localparam logic signed [2:0] DELTA [16] = '{
    -3'sd1, -3'sd1, 3'sd0, 3'sd0, 3'sd1, 3'sd2, 3'sd2, 3'sd3,
    -3'sd1, -3'sd1, 3'sd0, 3'sd0, 3'sd1, 3'sd2, 3'sd2, 3'sd3
  };

  localparam logic signed [7:0] STEP [16][16] = '{
    '{8'sd0, 8'sd0,  8'sd1,  8'sd2,  8'sd3,  8'sd5,   8'sd7,   8'sd10,  8'sd0,  8'sd0,   -8'sd1,  -8'sd2,  -8'sd3,  -8'sd5,   -8'sd7,   -8'sd10},
    '{8'sd0, 8'sd1,  8'sd2,  8'sd3,  8'sd4,  8'sd6,   8'sd8,   8'sd13,  8'sd0,  -8'sd1,  -8'sd2,  -8'sd3,  -8'sd4,  -8'sd6,   -8'sd8,   -8'sd13},
    '{8'sd0, 8'sd1,  8'sd2,  8'sd4,  8'sd5,  8'sd7,   8'sd10,  8'sd15,  8'sd0,  -8'sd1,  -8'sd2,  -8'sd4,  -8'sd5,  -8'sd7,   -8'sd10,  -8'sd15},
    '{8'sd0, 8'sd1,  8'sd3,  8'sd4,  8'sd6,  8'sd9,   8'sd13,  8'sd19,  8'sd0,  -8'sd1,  -8'sd3,  -8'sd4,  -8'sd6,  -8'sd9,   -8'sd13,  -8'sd19},
    '{8'sd0, 8'sd2,  8'sd3,  8'sd5,  8'sd8,  8'sd11,  8'sd15,  8'sd23,  8'sd0,  -8'sd2,  -8'sd3,  -8'sd5,  -8'sd8,  -8'sd11,  -8'sd15,  -8'sd23},
    '{8'sd0, 8'sd2,  8'sd4,  8'sd7,  8'sd10, 8'sd14,  8'sd19,  8'sd29,  8'sd0,  -8'sd2,  -8'sd4,  -8'sd7,  -8'sd10, -8'sd14,  -8'sd19,  -8'sd29},
    '{8'sd0, 8'sd3,  8'sd5,  8'sd8,  8'sd12, 8'sd16,  8'sd22,  8'sd33,  8'sd0,  -8'sd3,  -8'sd5,  -8'sd8,  -8'sd12, -8'sd16,  -8'sd22,  -8'sd33},
    '{8'sd1, 8'sd4,  8'sd7,  8'sd10, 8'sd15, 8'sd20,  8'sd29,  8'sd43,  -8'sd1, -8'sd4,  -8'sd7,  -8'sd10, -8'sd15, -8'sd20,  -8'sd29,  -8'sd43},
    '{8'sd1, 8'sd4,  8'sd8,  8'sd13, 8'sd18, 8'sd25,  8'sd35,  8'sd53,  -8'sd1, -8'sd4,  -8'sd8,  -8'sd13, -8'sd18, -8'sd25,  -8'sd35,  -8'sd53},
    '{8'sd1, 8'sd6,  8'sd10, 8'sd16, 8'sd22, 8'sd31,  8'sd43,  8'sd64,  -8'sd1, -8'sd6,  -8'sd10, -8'sd16, -8'sd22, -8'sd31,  -8'sd43,  -8'sd64},
    '{8'sd2, 8'sd7,  8'sd12, 8'sd19, 8'sd27, 8'sd37,  8'sd51,  8'sd76,  -8'sd2, -8'sd7,  -8'sd12, -8'sd19, -8'sd27, -8'sd37,  -8'sd51,  -8'sd76},
    '{8'sd2, 8'sd9,  8'sd16, 8'sd24, 8'sd34, 8'sd46,  8'sd64,  8'sd96,  -8'sd2, -8'sd9,  -8'sd16, -8'sd24, -8'sd34, -8'sd46,  -8'sd64,  -8'sd96},
    '{8'sd3, 8'sd11, 8'sd19, 8'sd29, 8'sd41, 8'sd57,  8'sd79,  8'sd117, -8'sd3, -8'sd11, -8'sd19, -8'sd29, -8'sd41, -8'sd57,  -8'sd79,  -8'sd117},
    '{8'sd4, 8'sd13, 8'sd24, 8'sd36, 8'sd50, 8'sd69,  8'sd96,  8'sd127, -8'sd4, -8'sd13, -8'sd24, -8'sd36, -8'sd50, -8'sd69,  -8'sd96,  -8'sd127},
    '{8'sd4, 8'sd16, 8'sd29, 8'sd44, 8'sd62, 8'sd85,  8'sd118, 8'sd127, -8'sd4, -8'sd16, -8'sd29, -8'sd44, -8'sd62, -8'sd85,  -8'sd118, -8'sd127},
    '{8'sd6, 8'sd20, 8'sd36, 8'sd54, 8'sd76, 8'sd106, 8'sd127, 8'sd127, -8'sd6, -8'sd20, -8'sd36, -8'sd54, -8'sd76, -8'sd106, -8'sd127, -8'sd127}
  };

  function automatic logic [3:0] clamp_idx(input logic [3:0] s, input logic signed [2:0] d);
    logic signed [5:0] t;
    t = $signed({2'b00, s}) + $signed({{3{d[2]}}, d});
    if (t < 6'sd0) return 4'd0;
    if (t > 6'sd15) return 4'd15;
    return t[3:0];
  endfunction

  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {a[7], a} + {b[7], b};
    if (t[8] != t[7]) return t[8] ? SMIN : SMAX;
    return t[7:0];
  endfunction

endpackage

// File: rtl/jt7759_adpcm_rom.sv
// Registered step lookup (state, code) -> step; first pipeline stage of the decoder.
module jt7759_adpcm_rom
  import jt7759_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] state,
  input  logic [3:0] code,
  output logic [7:0] step
);

  always_ff @(posedge clk) begin
    if (rst) step <= '0;
    else if (en) step <= STEP[state][code];
  end

endmodule

// File: rtl/jt7759_adpcm.sv
// uPD7759 ADPCM decode: byte buffer -> nibble codes -> step lookup -> saturating accumulator.
// state     | meaning
// BUF_EMPTY | no byte held; din_ok latches a new one
// BUF_HI    | byte held, high nibble is next
// BUF_LO    | byte held, low nibble is next; may refill as it is consumed
module jt7759_adpcm
  import jt7759_pkg::*;
#(
  parameter int SW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_dec,
  input  logic          rst_lvl,
  input  logic [7:0]    din,
  input  logic          din_ok,
  output logic          din_rd,
  output logic          underrun,
  output logic [SW-1:0] sound
);

  buf_st_t bst, bst_nxt;
  logic [7:0] byte_buf;
  logic latch, consume, ur_nxt;
  logic [3:0] code, state_idx;
  logic [7:0] step;
  logic step_vld;
  logic signed [7:0] sample;
  logic signed [SW-1:0] sample_ext;

  assign code = (bst == BUF_HI) ? byte_buf[7:4] : byte_buf[3:0];

  always_comb begin
    bst_nxt = bst;
    latch   = 1'b0;
    consume = 1'b0;
    ur_nxt  = 1'b0;
    case (bst)
      BUF_EMPTY: begin
        ur_nxt = cen_dec;
        if (din_ok) begin
          latch   = 1'b1;
          bst_nxt = BUF_HI;
        end
      end
      BUF_HI: begin
        if (cen_dec) begin
          consume = 1'b1;
          bst_nxt = BUF_LO;
        end
      end
      BUF_LO: begin
        if (cen_dec) begin
          consume = 1'b1;
          bst_nxt = BUF_EMPTY;
          if (din_ok) begin
            latch   = 1'b1;
            bst_nxt = BUF_HI;
          end
        end
      end
      default: bst_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || rst_lvl) begin
      bst      <= BUF_EMPTY;
      byte_buf <= '0;
      din_rd   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      bst      <= bst_nxt;
      din_rd   <= latch;
      underrun <= ur_nxt;
      if (latch) byte_buf <= din;
    end
  end

  jt7759_adpcm_rom u_rom (
    .clk   (clk),
    .rst   (rst),
    .en    (consume),
    .state (state_idx),
    .code  (code),
    .step  (step)
  );

  // rst_lvl also drops a step already looked up, so the accumulator restarts at zero
  always_ff @(posedge clk) begin
    if (rst || rst_lvl) begin
      state_idx <= '0;
      step_vld  <= 1'b0;
      sample    <= '0;
    end else begin
      step_vld <= consume;
      if (consume) state_idx <= clamp_idx(state_idx, DELTA[code]);
      if (step_vld) sample <= sat8(sample, step);
    end
  end

  assign sample_ext = SW'(sample);

  always_ff @(posedge clk) begin
    if (rst) sound <= '0;
    else sound <= sample_ext <<< (SW - 8);
  end

endmodule

// File: tb/tb_jt7759_adpcm.sv
// Directed bench for jt7759_adpcm: decode values, saturation, underrun, refill and restart.
module tb_jt7759_adpcm;

  logic clk = 1'b0;
  logic rst, cen_dec, rst_lvl, din_ok, din_rd, underrun;
  logic [7:0] din;
  logic [13:0] sound;
  logic hold_ok = 1'b0;
  int checks = 0;
  int errors = 0;

  jt7759_adpcm #(.SW(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen_dec  (cen_dec),
    .rst_lvl  (rst_lvl),
    .din      (din),
    .din_ok   (din_ok),
    .din_rd   (din_rd),
    .underrun (underrun),
    .sound    (sound)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic do_reset;
    rst = 1'b1; cen_dec = 1'b0; rst_lvl = 1'b0; din_ok = 1'b0; din = 8'h00; hold_ok = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] b, output logic rd);
    din = b; din_ok = 1'b1;
    @(negedge clk);
    rd = din_rd;
    din_ok = hold_ok;
  endtask

  // one cen_dec pulse; returns flags after E1 and sound after E2 and E3
  task automatic strobe(input logic dok, output logic rd, output logic ur,
                        output logic [13:0] s2, output logic [13:0] s3);
    cen_dec = 1'b1; din_ok = dok;
    @(negedge clk);
    cen_dec = 1'b0; din_ok = hold_ok;
    rd = din_rd; ur = underrun;
    @(negedge clk);
    s2 = sound;
    @(negedge clk);
    s3 = sound;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (sound !== 14'd0) begin errors++; $display("FAIL reset_sound got %0d exp 0", sound); end
    checks++; if (din_rd !== 1'b0) begin errors++; $display("FAIL reset_din_rd got %0b exp 0", din_rd); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %0b exp 0", underrun); end
    checks++; if (dut.state_idx !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dut.state_idx); end
  endtask

  task automatic test_basic;
    logic rd, ur;
    logic [13:0] s2, s3;
    do_reset();
    load(8'h77, rd);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL basic_din_rd got %0b exp 1", rd); end
    @(negedge clk);
    checks++; if (din_rd !== 1'b0) begin errors++; $display("FAIL basic_din_rd_once got %0b exp 0", din_rd); end
    strobe(1'b0, rd, ur, s2, s3);
    checks++; if (s2 !== 14'd0) begin errors++; $display("FAIL basic_lat1 got %0d exp 0", s2); end
    checks++; if (s3 !== 14'd640) begin errors++; $display("FAIL basic_s1 got %0d exp 640", s3); end
    checks++; if (dut.state_idx !== 4'd3) begin errors++; $display("FAIL basic_state1 got %0d exp 3", dut.state_idx); end
    strobe(1'b0, rd, ur, s2, s3);
    checks++; if (s2 !== 14'd640) begin errors++; $display("FAIL basic_lat2 got %0d exp 640", s2); end
    checks++; if (s3 !== 14'd1856) begin errors++; $display("FAIL basic_s2 got %0d exp 1856", s3); end
    checks++; if (dut.state_idx !== 4'd6) begin errors++; $display("FAIL basic_state2 got %0d exp 6", dut.state_idx); end
    checks++; if (ur !== 1'b0) begin errors++; $display("FAIL basic_underrun got %0b exp 0", ur); end
  endtask

  task automatic test_zero;
    logic rd, ur;
    logic [13:0] s2, s3;
    do_reset();
    load(8'h00, rd);
    for (int k = 0; k < 2; k++) begin
      strobe(1'b0, rd, ur, s2, s3);
      checks++; if (s3 !== 14'd0) begin errors++; $display("FAIL zero_sound%0d got %0d exp 0", k, s3); end
      checks++; if (ur !== 1'b0) begin errors++; $display("FAIL zero_underrun%0d got %0b exp 0", k, ur); end
      checks++; if (dut.state_idx !== 4'd0) begin errors++; $display("FAIL zero_state%0d got %0d exp 0", k, dut.state_idx); end
    end
  endtask

  task automatic test_saturate;
    logic rd, ur;
    logic [13:0] s2, s3, ex;
    int exp_s [18] = '{10, 29, 62, 126, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 0, -127};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      load((i < 8) ? 8'h77 : 8'hFF, rd);
      checks++; if (rd !== 1'b1) begin errors++; $display("FAIL sat_din_rd%0d got %0b exp 1", i, rd); end
      for (int j = 0; j < 2; j++) begin
        strobe(1'b0, rd, ur, s2, s3);
        ex = 14'(exp_s[2*i+j] * 64);
        checks++; if (s3 !== ex) begin errors++; $display("FAIL sat_sound%0d got %0d exp %0d", 2*i+j, s3, ex); end
      end
      if (i == 7) begin
        checks++; if (dut.state_idx !== 4'd15) begin errors++; $display("FAIL sat_state got %0d exp 15", dut.state_idx); end
      end
    end
  endtask

  task automatic test_underrun;
    logic rd, ur;
    logic [13:0] s2, s3;
    do_reset();
    strobe(1'b0, rd, ur, s2, s3);
    checks++; if (ur !== 1'b1) begin errors++; $display("FAIL ur1_flag got %0b exp 1", ur); end
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL ur1_din_rd got %0b exp 0", rd); end
    checks++; if (s3 !== 14'd0) begin errors++; $display("FAIL ur1_sound got %0d exp 0", s3); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur1_pulse got %0b exp 0", underrun); end
    din = 8'h77;
    strobe(1'b1, rd, ur, s2, s3);
    checks++; if (ur !== 1'b1) begin errors++; $display("FAIL ur2_flag got %0b exp 1", ur); end
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL ur2_din_rd got %0b exp 1", rd); end
    checks++; if (s3 !== 14'd0) begin errors++; $display("FAIL ur2_sound got %0d exp 0", s3); end
    strobe(1'b0, rd, ur, s2, s3);
    checks++; if (ur !== 1'b0) begin errors++; $display("FAIL ur3_flag got %0b exp 0", ur); end
    checks++; if (s3 !== 14'd640) begin errors++; $display("FAIL ur3_sound got %0d exp 640", s3); end
  endtask

  task automatic test_back_to_back;
    logic rd, ur;
    logic [13:0] s2, s3;
    do_reset();
    hold_ok = 1'b1;
    load(8'h77, rd);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL b2b_first_rd got %0b exp 1", rd); end
    @(negedge clk);
    checks++; if (din_rd !== 1'b0) begin errors++; $display("FAIL b2b_full_rd got %0b exp 0", din_rd); end
    strobe(1'b1, rd, ur, s2, s3);
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL b2b_hi_rd got %0b exp 0", rd); end
    checks++; if (s3 !== 14'd640) begin errors++; $display("FAIL b2b_hi_sound got %0d exp 640", s3); end
    strobe(1'b1, rd, ur, s2, s3);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL b2b_refill_rd got %0b exp 1", rd); end
    checks++; if (ur !== 1'b0) begin errors++; $display("FAIL b2b_lo_ur got %0b exp 0", ur); end
    checks++; if (s3 !== 14'd1856) begin errors++; $display("FAIL b2b_lo_sound got %0d exp 1856", s3); end
    strobe(1'b1, rd, ur, s2, s3);
    checks++; if (ur !== 1'b0) begin errors++; $display("FAIL b2b_next_ur got %0b exp 0", ur); end
    checks++; if (s3 !== 14'd3968) begin errors++; $display("FAIL b2b_next_sound got %0d exp 3968", s3); end
    hold_ok = 1'b0; din_ok = 1'b0;
  endtask

  task automatic test_rst_lvl;
    logic rd, ur;
    logic [13:0] s2, s3;
    do_reset();
    load(8'h77, rd);
    strobe(1'b0, rd, ur, s2, s3);
    strobe(1'b0, rd, ur, s2, s3);
    checks++; if (s3 !== 14'd1856) begin errors++; $display("FAIL lvl_pre_sound got %0d exp 1856", s3); end
    load(8'h77, rd);
    cen_dec = 1'b1; rst_lvl = 1'b1;
    @(negedge clk);
    cen_dec = 1'b0; rst_lvl = 1'b0;
    checks++; if (dut.state_idx !== 4'd0) begin errors++; $display("FAIL lvl_state got %0d exp 0", dut.state_idx); end
    checks++; if (dut.sample !== 8'sd0) begin errors++; $display("FAIL lvl_sample got %0d exp 0", dut.sample); end
    checks++; if (sound !== 14'd1856) begin errors++; $display("FAIL lvl_sound_hold got %0d exp 1856", sound); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL lvl_underrun got %0b exp 0", underrun); end
    @(negedge clk);
    checks++; if (sound !== 14'd0) begin errors++; $display("FAIL lvl_sound_clr got %0d exp 0", sound); end
    strobe(1'b0, rd, ur, s2, s3);
    checks++; if (ur !== 1'b1) begin errors++; $display("FAIL lvl_buf_empty got %0b exp 1", ur); end
    load(8'h77, rd);
    strobe(1'b0, rd, ur, s2, s3);
    checks++; if (s3 !== 14'd640) begin errors++; $display("FAIL lvl_restart got %0d exp 640", s3); end
    cen_dec = 1'b1;
    @(negedge clk);
    cen_dec = 1'b0; rst_lvl = 1'b1;
    @(negedge clk);
    rst_lvl = 1'b0;
    checks++; if (dut.sample !== 8'sd0) begin errors++; $display("FAIL lvl_inflight_sample got %0d exp 0", dut.sample); end
    checks++; if (dut.state_idx !== 4'd0) begin errors++; $display("FAIL lvl_inflight_state got %0d exp 0", dut.state_idx); end
    repeat (3) @(negedge clk);
    checks++; if (sound !== 14'd0) begin errors++; $display("FAIL lvl_inflight_sound got %0d exp 0", sound); end
  endtask

  initial begin
    rst = 1'b1; cen_dec = 1'b0; rst_lvl = 1'b0; din_ok = 1'b0; din = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_saturate();
    test_underrun();
    test_back_to_back();
    test_rst_lvl();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
